// File: rtl/loteria_n.sv
`default_nettype none
// ============================================================================
//  Module   : loteria_n
//  Purpose  : Parametrised lottery ticket checker. Collects BCD digits with
//             undo support, grades positional matches against SECRET into
//             prize tiers, and drives active-low 7-segment patterns.
//  Revision : 1.0  initial release
// ============================================================================
module loteria_n #(
    parameter int                    N_DIGITS = 5,
    parameter logic [4*N_DIGITS-1:0] SECRET   = 20'h50967,
    parameter int                    N_PRIZES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              num,
    input  logic                    insert,
    input  logic                    undo,
    input  logic                    finish,
    output logic [1:0]              state_o,
    output logic [3:0]              count_o,
    output logic [3:0]              matches_o,
    output logic [3:0]              prize_o,
    output logic                    win,
    output logic                    err,
    output logic [7*N_DIGITS-1:0]   hex_digits,
    output logic [6:0]              hex_prize
);

    typedef enum logic [1:0] {
        ST_ENTRY  = 2'd0,
        ST_READY  = 2'd1,
        ST_CHECK  = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    localparam logic [3:0] C_N_DIGITS = 4'(N_DIGITS);
    localparam logic [3:0] C_N_PRIZES = 4'(N_PRIZES);
    localparam logic [6:0] C_DASH     = 7'b0111111;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = C_DASH;
        endcase
    endfunction

    state_t                     state_q, state_d;
    logic [3:0]                 count_q, count_d;
    logic [3:0]                 matches_q, matches_d;
    logic [3:0]                 prize_q, prize_d;
    logic                       win_q, win_d;
    logic                       err_q, err_d;
    logic [N_DIGITS-1:0][3:0]   digit_q, digit_d;
    logic [N_DIGITS-1:0]        flag_q, flag_d;
    logic                       insert_q, insert_d;
    logic                       undo_q, undo_d;
    logic                       finish_q, finish_d;

    logic                       w_undo_ev, w_insert_ev, w_finish_ev, w_num_ok;
    logic [3:0]                 w_pop, w_miss, w_prize;

    // Strict priority: a higher-priority event masks the lower ones that cycle
    assign w_undo_ev   = undo & ~undo_q;
    assign w_insert_ev = insert & ~insert_q & ~w_undo_ev;
    assign w_finish_ev = finish & ~finish_q & ~w_undo_ev & ~w_insert_ev;
    assign w_num_ok    = (num <= 4'd9);

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            w_pop = w_pop + {3'b000, flag_q[i]};
        end
    end

    assign w_miss  = C_N_DIGITS - w_pop;
    assign w_prize = (w_miss < C_N_PRIZES) ? w_miss + 4'd1 : 4'd0;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        matches_d = matches_q;
        prize_d   = prize_q;
        win_d     = win_q;
        err_d     = 1'b0;
        digit_d   = digit_q;
        flag_d    = flag_q;
        insert_d  = insert;
        undo_d    = undo;
        finish_d  = finish;

        if (state_q == ST_CHECK) begin
            matches_d = w_pop;
            prize_d   = w_prize;
            win_d     = (w_prize != 4'd0);
            state_d   = ST_RESULT;
        end else if (w_undo_ev) begin
            if (state_q != ST_RESULT && count_q != 4'd0) begin
                for (int i = 0; i < N_DIGITS; i++) begin
                    if (count_q == 4'(i + 1)) begin
                        flag_d[i] = 1'b0;
                    end
                end
                count_d = count_q - 4'd1;
                state_d = ST_ENTRY;
            end
        end else if (w_insert_ev) begin
            if (!w_num_ok) begin
                err_d = 1'b1;
            end else if (state_q == ST_ENTRY) begin
                for (int i = 0; i < N_DIGITS; i++) begin
                    if (count_q == 4'(i)) begin
                        digit_d[i] = num;
                        flag_d[i]  = (num == SECRET[4*(N_DIGITS-1-i) +: 4]);
                    end
                end
                count_d = count_q + 4'd1;
                if (count_q + 4'd1 == C_N_DIGITS) begin
                    state_d = ST_READY;
                end
            end else if (state_q == ST_RESULT) begin
                // Start a fresh ticket with this digit in position 0
                flag_d     = '0;
                flag_d[0]  = (num == SECRET[4*N_DIGITS-1 -: 4]);
                digit_d[0] = num;
                count_d    = 4'd1;
                matches_d  = 4'd0;
                prize_d    = 4'd0;
                win_d      = 1'b0;
                state_d    = (N_DIGITS == 1) ? ST_READY : ST_ENTRY;
            end
        end else if (w_finish_ev && state_q == ST_READY) begin
            state_d = ST_CHECK;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_ENTRY;
            count_q   <= 4'd0;
            matches_q <= 4'd0;
            prize_q   <= 4'd0;
            win_q     <= 1'b0;
            err_q     <= 1'b0;
            digit_q   <= '0;
            flag_q    <= '0;
            insert_q  <= 1'b0;
            undo_q    <= 1'b0;
            finish_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            matches_q <= matches_d;
            prize_q   <= prize_d;
            win_q     <= win_d;
            err_q     <= err_d;
            digit_q   <= digit_d;
            flag_q    <= flag_d;
            insert_q  <= insert_d;
            undo_q    <= undo_d;
            finish_q  <= finish_d;
        end
    end

    assign state_o   = state_q;
    assign count_o   = count_q;
    assign matches_o = matches_q;
    assign prize_o   = prize_q;
    assign win       = win_q;
    assign err       = err_q;
    assign hex_prize = seg7(prize_q);

    generate
        for (genvar i = 0; i < N_DIGITS; i++) begin : g_slot
            assign hex_digits[7*(N_DIGITS-i)-1 -: 7] =
                (count_q > 4'(i)) ? seg7(digit_q[i]) : C_DASH;
        end
    endgenerate

endmodule
`default_nettype wire
